// File: rtl/agu_pkg.sv
// agu_pkg: shared types and constants for the AGU execute stage.
// Entry layout of the address FIFO and CDB/PRF/ROB widths.
package agu_pkg;

  localparam int CDB_LANES = 5;
  localparam int PREG_W    = 6;
  localparam int ROB_W     = 6;

  typedef struct packed {
    logic [31:0]      addr;
    logic [ROB_W-1:0] tag_rob;
  } agu_entry_t;

endpackage

// File: rtl/agu_pipe_if.sv
// agu_pipe_if: address handoff from the AGU stage to the LSU.
// master = AGU (valid_addr/addr/tag_rob_addr out, ready_lsu in).
interface agu_pipe_if;
  import agu_pkg::*;

  logic             valid_addr;
  logic [31:0]      addr;
  logic [ROB_W-1:0] tag_rob_addr;
  logic             ready_lsu;

  modport master (
    output valid_addr, addr, tag_rob_addr,
    input  ready_lsu
  );

  modport slave (
    input  valid_addr, addr, tag_rob_addr,
    output ready_lsu
  );

endinterface

// File: rtl/agu_fifo.sv
// agu_fifo: DEPTH-entry FIFO of agu_entry_t with flush.
// Ports: push/din, pop, flush, head (registered storage), count.
module agu_fifo
  import agu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  agu_entry_t       din,
  output agu_entry_t       head,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  agu_entry_t       mem_q [DEPTH];
  agu_entry_t       mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  // Push into a full FIFO is accepted only when the head
  // leaves in the same cycle; otherwise it is dropped.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      // Storage is cleared too so head reads back as zero.
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && !flush)
      assert (!(push && full && !pop))
        else $error("agu_fifo: push into full fifo");
  end
`endif

endmodule

// File: rtl/agu_pipe.sv
// agu_pipe: AGU execute stage, S1 reg + CDB bypass + adder + FIFO.
// Ports: issue uop in, rf read, 5 CDB lanes, lsu (agu_pipe_if), hold_issue.
// Macro AGU_PERF_CNT_EN adds perf_addr_cnt / perf_hold_cnt outputs.
module agu_pipe
  import agu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               ready_awake,
  input  logic [PREG_W-1:0]                  Pj_awake,
  input  logic [31:0]                        imm_awake,
  input  logic [ROB_W-1:0]                   tag_rob_awake,
  output logic [PREG_W-1:0]                  rf_raddr,
  input  logic [31:0]                        rf_rdata,
  input  logic [CDB_LANES-1:0]               ready_cdb,
  input  logic [CDB_LANES-1:0]               RegWr_cdb,
  input  logic [CDB_LANES-1:0][PREG_W-1:0]   Pd_cdb,
  input  logic [CDB_LANES-1:0][31:0]         data_cdb,
  agu_pipe_if.master                         lsu,
  output logic                               hold_issue
`ifdef AGU_PERF_CNT_EN
  ,
  output logic [31:0]                        perf_addr_cnt,
  output logic [31:0]                        perf_hold_cnt
`endif
);

  logic              s1_valid_q, s1_valid_d;
  logic [PREG_W-1:0] s1_pj_q, s1_pj_d;
  logic [31:0]       s1_imm_q, s1_imm_d;
  logic [ROB_W-1:0]  s1_tag_q, s1_tag_d;
  logic [31:0]       base;
  logic [31:0]       addr_s1;
  agu_entry_t        push_entry;
  agu_entry_t        head;
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic              pop;

  always_comb begin
    s1_valid_d = 1'b0;
    s1_pj_d    = '0;
    s1_imm_d   = '0;
    s1_tag_d   = '0;
    if (ready_awake && !flush) begin
      s1_valid_d = 1'b1;
      s1_pj_d    = Pj_awake;
      s1_imm_d   = imm_awake;
      s1_tag_d   = tag_rob_awake;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_pj_q    <= '0;
      s1_imm_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pj_q    <= s1_pj_d;
      s1_imm_q   <= s1_imm_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign rf_raddr = s1_pj_q;

  // Scan high to low so the lowest matching lane wins.
  always_comb begin
    base = rf_rdata;
    for (int i = CDB_LANES - 1; i >= 0; i--) begin
      if (ready_cdb[i] && RegWr_cdb[i] && (Pd_cdb[i] == s1_pj_q))
        base = data_cdb[i];
    end
  end

  assign addr_s1    = base + s1_imm_q;
  assign push_entry = {addr_s1, s1_tag_q};

  agu_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .flush (flush),
    .push  (s1_valid_q),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign valid            = (count != '0);
  assign pop              = valid && lsu.ready_lsu;
  assign lsu.valid_addr   = valid;
  assign lsu.addr         = head.addr;
  assign lsu.tag_rob_addr = head.tag_rob;

  // Leaves room for the uop in S1 plus one already woken.
  assign hold_issue = (count >= CNT_W'(DEPTH - 2));

`ifdef AGU_PERF_CNT_EN
  logic [31:0] perf_addr_q, perf_addr_d;
  logic [31:0] perf_hold_q, perf_hold_d;

  always_comb begin
    perf_addr_d = perf_addr_q;
    perf_hold_d = perf_hold_q;
    if (pop && !flush) perf_addr_d = perf_addr_q + 32'd1;
    if (hold_issue)    perf_hold_d = perf_hold_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_addr_q <= '0;
      perf_hold_q <= '0;
    end else begin
      perf_addr_q <= perf_addr_d;
      perf_hold_q <= perf_hold_d;
    end
  end

  assign perf_addr_cnt = perf_addr_q;
  assign perf_hold_cnt = perf_hold_q;
`endif

endmodule

// File: tb/tb_agu_pipe.sv
// tb_agu_pipe: scoreboard bench for agu_pipe.
// Expected entries are queued at issue and popped at LSU handoff.
module tb_agu_pipe;
  import agu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  ready_awake = 1'b0;
  logic [5:0]            Pj_awake = '0;
  logic [31:0]           imm_awake = '0;
  logic [5:0]            tag_rob_awake = '0;
  logic [5:0]            rf_raddr;
  logic [31:0]           rf_rdata;
  logic [4:0]            ready_cdb = '0;
  logic [4:0]            RegWr_cdb = '0;
  logic [4:0][5:0]       Pd_cdb = '0;
  logic [4:0][31:0]      data_cdb = '0;
  logic                  hold_issue;
`ifdef AGU_PERF_CNT_EN
  logic [31:0]           perf_addr_cnt;
  logic [31:0]           perf_hold_cnt;
`endif

  logic [31:0] rf_mem [64];
  agu_entry_t  q [$];
  int          n_tests = 0;
  int          n_fail = 0;

  agu_pipe_if lsu_if ();

  assign rf_rdata = rf_mem[rf_raddr];

  agu_pipe #(
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ready_awake   (ready_awake),
    .Pj_awake      (Pj_awake),
    .imm_awake     (imm_awake),
    .tag_rob_awake (tag_rob_awake),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .ready_cdb     (ready_cdb),
    .RegWr_cdb     (RegWr_cdb),
    .Pd_cdb        (Pd_cdb),
    .data_cdb      (data_cdb),
    .lsu           (lsu_if),
    .hold_issue    (hold_issue)
`ifdef AGU_PERF_CNT_EN
    ,
    .perf_addr_cnt (perf_addr_cnt),
    .perf_hold_cnt (perf_hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [5:0] pj, input logic [31:0] imm,
                      input logic [5:0] tag);
    ready_awake   = 1'b1;
    Pj_awake      = pj;
    imm_awake     = imm;
    tag_rob_awake = tag;
    @(posedge clk); #1;
    ready_awake   = 1'b0;
    Pj_awake      = '0;
    imm_awake     = '0;
    tag_rob_awake = '0;
  endtask

  task automatic clear_cdb();
    ready_cdb = '0;
    RegWr_cdb = '0;
    Pd_cdb    = '0;
    data_cdb  = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) rf_mem[i] = '0;
    lsu_if.ready_lsu = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (lsu_if.valid_addr !== 1'b0 || lsu_if.addr !== 32'h0 ||
        lsu_if.tag_rob_addr !== 6'h0 || hold_issue !== 1'b0 ||
        rf_raddr !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b addr=%h tag=%h hold=%b raddr=%h want 0",
               lsu_if.valid_addr, lsu_if.addr, lsu_if.tag_rob_addr,
               hold_issue, rf_raddr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    agu_entry_t e;
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b1;
    rf_mem[5] = 32'h0000_1000;
    send(6'd5, 32'h10, 6'd3);
    q.push_back({32'h0000_1010, 6'd3});
    @(negedge clk);
    n_tests++;
    if (rf_raddr !== 6'd5 || lsu_if.valid_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL single_s1: raddr=%0d valid=%b want 5 0",
               rf_raddr, lsu_if.valid_addr);
    end
    @(negedge clk);
    e = q.pop_front();
    n_tests++;
    if (lsu_if.valid_addr !== 1'b1 || lsu_if.addr !== e.addr ||
        lsu_if.tag_rob_addr !== e.tag_rob) begin
      n_fail++;
      $display("FAIL single_out: valid=%b addr=%h tag=%0d want 1 %h %0d",
               lsu_if.valid_addr, lsu_if.addr, lsu_if.tag_rob_addr,
               e.addr, e.tag_rob);
    end
    @(negedge clk);
    n_tests++;
    if (lsu_if.valid_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b want 0", lsu_if.valid_addr);
    end
  endtask

  task automatic test_bypass();
    agu_entry_t x;
    int got;
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b0;
    rf_mem[7]  = 32'h0000_DEAD;
    rf_mem[8]  = 32'h0000_0100;
    rf_mem[11] = 32'h0000_0055;
    send(6'd7, 32'hFFFF_FFFC, 6'd9);
    q.push_back({32'h0000_1FFC, 6'd9});
    ready_cdb = 5'b01011;
    RegWr_cdb = 5'b11110;
    Pd_cdb[0] = 6'd7;  data_cdb[0] = 32'h0000_9999;
    Pd_cdb[1] = 6'd7;  data_cdb[1] = 32'h0000_2000;
    Pd_cdb[3] = 6'd7;  data_cdb[3] = 32'h0000_3000;
    send(6'd8, 32'h4, 6'd10);
    q.push_back({32'h0000_0104, 6'd10});
    clear_cdb();
    ready_cdb = 5'b00011;
    RegWr_cdb = 5'b00001;
    Pd_cdb[0] = 6'd9;  data_cdb[0] = 32'h0000_7777;
    Pd_cdb[1] = 6'd8;  data_cdb[1] = 32'h0000_6666;
    send(6'd11, 32'h0, 6'd11);
    q.push_back({32'h0000_ABCD, 6'd11});
    clear_cdb();
    ready_cdb = 5'b10100;
    RegWr_cdb = 5'b10100;
    Pd_cdb[2] = 6'd12; data_cdb[2] = 32'h0000_1111;
    Pd_cdb[4] = 6'd11; data_cdb[4] = 32'h0000_ABCD;
    @(posedge clk); #1;
    clear_cdb();
    lsu_if.ready_lsu = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
        n_tests++;
        x = q.pop_front();
        if (lsu_if.addr !== x.addr || lsu_if.tag_rob_addr !== x.tag_rob) begin
          n_fail++;
          $display("FAIL bypass_%0d: addr=%h tag=%0d want %h %0d",
                   got, lsu_if.addr, lsu_if.tag_rob_addr, x.addr, x.tag_rob);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL bypass_timeout: got %0d entries want 3", got);
    end
  endtask

  task automatic test_wrap();
    agu_entry_t x;
    int got;
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b0;
    rf_mem[2] = 32'hFFFF_FFF0;
    rf_mem[3] = 32'h0000_0008;
    rf_mem[0] = 32'h0000_0001;
    send(6'd2, 32'h20, 6'd4);
    q.push_back({32'h0000_0010, 6'd4});
    send(6'd3, 32'hFFFF_FFF0, 6'd5);
    q.push_back({32'hFFFF_FFF8, 6'd5});
    send(6'd0, 32'h7FFF_FFFF, 6'd6);
    q.push_back({32'h8000_0000, 6'd6});
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
        n_tests++;
        x = q.pop_front();
        if (lsu_if.addr !== x.addr || lsu_if.tag_rob_addr !== x.tag_rob) begin
          n_fail++;
          $display("FAIL wrap_%0d: addr=%h tag=%0d want %h %0d",
                   got, lsu_if.addr, lsu_if.tag_rob_addr, x.addr, x.tag_rob);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL wrap_timeout: got %0d entries want 3", got);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b1;
    fork
      begin
        agu_entry_t e;
        logic [31:0] imm;
        for (int k = 0; k < 8; k++) begin
          rf_mem[40+k] = $urandom;
          imm          = $urandom;
          e.addr       = rf_mem[40+k] + imm;
          e.tag_rob    = 6'(32 + k);
          q.push_back(e);
          send(6'(40 + k), imm, e.tag_rob);
        end
      end
      begin
        agu_entry_t x;
        int got;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
          @(negedge clk);
          if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
            n_tests++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL b2b_extra: unexpected addr=%h", lsu_if.addr);
            end else begin
              x = q.pop_front();
              if (lsu_if.addr !== x.addr ||
                  lsu_if.tag_rob_addr !== x.tag_rob) begin
                n_fail++;
                $display("FAIL b2b_%0d: addr=%h tag=%0d want %h %0d", got,
                         lsu_if.addr, lsu_if.tag_rob_addr, x.addr, x.tag_rob);
              end
            end
            got++;
          end
        end
        n_tests++;
        if (got != 8) begin
          n_fail++;
          $display("FAIL b2b_timeout: got %0d entries want 8", got);
        end
      end
    join
  endtask

  task automatic test_backpressure();
    agu_entry_t e;
    agu_entry_t x;
    int cnt_m, s1_m, issued, got;
    logic prev_hold, iss;
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b0;
    cnt_m = 0; s1_m = 0; issued = 0; prev_hold = 1'b0;
    for (int it = 0; it < 8; it++) begin
      n_tests++;
      if (hold_issue !== (cnt_m >= 2)) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: hold=%b want %b (count %0d)",
                 it, hold_issue, (cnt_m >= 2), cnt_m);
      end
      // Issue queue registers its wake decision: it sees last cycle's hold.
      iss = !prev_hold && (issued < 4);
      ready_awake = iss;
      if (iss) begin
        rf_mem[20+issued] = 32'h100 * (issued + 1);
        Pj_awake      = 6'(20 + issued);
        imm_awake     = 32'(issued);
        tag_rob_awake = 6'(48 + issued);
        e.addr        = 32'h100 * (issued + 1) + 32'(issued);
        e.tag_rob     = 6'(48 + issued);
        q.push_back(e);
        issued++;
      end
      prev_hold = (cnt_m >= 2);
      @(posedge clk); #1;
      ready_awake = 1'b0;
      cnt_m = cnt_m + s1_m;
      s1_m  = iss ? 1 : 0;
    end
    n_tests++;
    if (lsu_if.valid_addr !== 1'b1 || hold_issue !== 1'b1 || cnt_m != 4) begin
      n_fail++;
      $display("FAIL bp_full: valid=%b hold=%b model_cnt=%0d want 1 1 4",
               lsu_if.valid_addr, hold_issue, cnt_m);
    end
    lsu_if.ready_lsu = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
        n_tests++;
        x = q.pop_front();
        if (lsu_if.addr !== x.addr || lsu_if.tag_rob_addr !== x.tag_rob) begin
          n_fail++;
          $display("FAIL bp_drain_%0d: addr=%h tag=%0d want %h %0d",
                   got, lsu_if.addr, lsu_if.tag_rob_addr, x.addr, x.tag_rob);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d entries want 4", got);
    end
    @(posedge clk); #1;
    n_tests++;
    if (hold_issue !== 1'b0 || lsu_if.valid_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: hold=%b valid=%b want 0 0",
               hold_issue, lsu_if.valid_addr);
    end
  endtask

  task automatic test_flush();
    agu_entry_t x;
    int got;
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rf_mem[50+k] = 32'hC000_0000 + 32'(k);
      send(6'(50 + k), 32'h0, 6'(k + 1));
    end
    n_tests++;
    if (lsu_if.valid_addr !== 1'b1 || hold_issue !== 1'b1 ||
        rf_raddr !== 6'd53) begin
      n_fail++;
      $display("FAIL flush_pre: valid=%b hold=%b raddr=%0d want 1 1 53",
               lsu_if.valid_addr, hold_issue, rf_raddr);
    end
    flush         = 1'b1;
    ready_awake   = 1'b1;
    Pj_awake      = 6'd60;
    imm_awake     = 32'h4;
    tag_rob_awake = 6'd60;
    @(posedge clk); #1;
    flush       = 1'b0;
    ready_awake = 1'b0;
    Pj_awake    = '0;
    imm_awake   = '0;
    tag_rob_awake = '0;
    n_tests++;
    if (lsu_if.valid_addr !== 1'b0 || hold_issue !== 1'b0 ||
        lsu_if.addr !== 32'h0 || lsu_if.tag_rob_addr !== 6'h0 ||
        rf_raddr !== 6'h0) begin
      n_fail++;
      $display("FAIL flush_state: valid=%b hold=%b addr=%h tag=%h raddr=%h want 0",
               lsu_if.valid_addr, hold_issue, lsu_if.addr,
               lsu_if.tag_rob_addr, rf_raddr);
    end
    lsu_if.ready_lsu = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (lsu_if.valid_addr !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale_%0d: valid=%b addr=%h want valid 0",
                 c, lsu_if.valid_addr, lsu_if.addr);
      end
    end
    @(posedge clk); #1;
    rf_mem[61] = 32'h0000_5000;
    send(6'd61, 32'h8, 6'd33);
    q.push_back({32'h0000_5008, 6'd33});
    got = 0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      @(negedge clk);
      if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
        n_tests++;
        x = q.pop_front();
        if (lsu_if.addr !== x.addr || lsu_if.tag_rob_addr !== x.tag_rob) begin
          n_fail++;
          $display("FAIL flush_after: addr=%h tag=%0d want %h %0d",
                   lsu_if.addr, lsu_if.tag_rob_addr, x.addr, x.tag_rob);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 1) begin
      n_fail++;
      $display("FAIL flush_after_timeout: got %0d want 1", got);
    end
  endtask

`ifdef AGU_PERF_CNT_EN
  task automatic test_perf();
    agu_entry_t x;
    int got;
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++;
    if (perf_addr_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset0: addr_cnt=%0d hold_cnt=%0d want 0 0",
               perf_addr_cnt, perf_hold_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rf_mem[k+24] = 32'h0000_2000 + 32'(k);
      send(6'(k + 24), 32'h10, 6'(k + 40));
      q.push_back({32'h0000_2010 + 32'(k), 6'(k + 40)});
    end
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
        n_tests++;
        x = q.pop_front();
        if (lsu_if.addr !== x.addr || lsu_if.tag_rob_addr !== x.tag_rob) begin
          n_fail++;
          $display("FAIL perf_drain_%0d: addr=%h want %h", got,
                   lsu_if.addr, x.addr);
        end
        got++;
      end
    end
    @(posedge clk); #1;
    send(6'd30, 32'h1, 6'd50);
    q.push_back({32'h0000_0001, 6'd50});
    send(6'd31, 32'h2, 6'd51);
    q.push_back({32'h0000_0002, 6'd51});
    rf_mem[30] = 32'h0;
    rf_mem[31] = 32'h0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      if (lsu_if.valid_addr && lsu_if.ready_lsu) begin
        n_tests++;
        x = q.pop_front();
        if (lsu_if.addr !== x.addr || lsu_if.tag_rob_addr !== x.tag_rob) begin
          n_fail++;
          $display("FAIL perf_drain_%0d: addr=%h want %h", got,
                   lsu_if.addr, x.addr);
        end
        got++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (got != 5 || perf_addr_cnt !== 32'd5 || perf_hold_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_counts: pops=%0d addr_cnt=%0d hold_cnt=%0d want 5 5 3",
               got, perf_addr_cnt, perf_hold_cnt);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_tests++;
    if (perf_addr_cnt !== 32'd5 || perf_hold_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_flush: addr_cnt=%0d hold_cnt=%0d want 5 3",
               perf_addr_cnt, perf_hold_cnt);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (perf_addr_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_rst: addr_cnt=%0d hold_cnt=%0d want 0 0",
               perf_addr_cnt, perf_hold_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    @(posedge clk); #1;
    lsu_if.ready_lsu = 1'b0;
    rf_mem[5] = 32'h0000_1000;
    send(6'd5, 32'h10, 6'd3);
    send(6'd6, 32'h20, 6'd4);
    n_tests++;
    if (lsu_if.valid_addr !== 1'b1 || lsu_if.addr !== 32'h0000_1010 ||
        rf_raddr !== 6'd6) begin
      n_fail++;
      $display("FAIL rstmid_pre: valid=%b addr=%h raddr=%0d want 1 00001010 6",
               lsu_if.valid_addr, lsu_if.addr, rf_raddr);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (lsu_if.valid_addr !== 1'b0 || lsu_if.addr !== 32'h0 ||
        lsu_if.tag_rob_addr !== 6'h0 || hold_issue !== 1'b0 ||
        rf_raddr !== 6'h0) begin
      n_fail++;
      $display("FAIL rstmid_state: valid=%b addr=%h tag=%h hold=%b raddr=%h want 0",
               lsu_if.valid_addr, lsu_if.addr, lsu_if.tag_rob_addr,
               hold_issue, rf_raddr);
    end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_bypass();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
`ifdef AGU_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
- Address-generation execute stage directly downstream of the AGU issue queue.
- Accepts one awakened load/store uop per cycle (Pj, imm, tag_rob).
- Reads the base register from the physical register file, with bypass from the 5 CDB lanes, and computes addr = base + imm.
- Buffers results in a small FIFO with valid/ready handoff to the LSU. Back-pressures the issue queue through hold_issue, because the issue queue itself has no stall input.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, >= 4)
- CNT_W, 3, FIFO occupancy counter width (log2(DEPTH)+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (branch mispredict / exception)
- ready_awake  in  1  issued uop valid
- Pj_awake  in  6  base physical register
- imm_awake  in  32  sign-extended offset
- tag_rob_awake  in  6  ROB tag
- rf_raddr  out  6  register-file read address (combinational from S1)
- rf_rdata  in  32  register-file read data (combinational, same cycle)
- ready_cdb  in  5x1  CDB lane valid
- RegWr_cdb  in  5x1  CDB lane writes a register
- Pd_cdb  in  5x6  CDB destination
- data_cdb  in  5x32  CDB result
- valid_addr  out  1  FIFO head valid to LSU
- addr  out  32  head address
- tag_rob_addr  out  6  head ROB tag
- ready_lsu  in  1  LSU accepts head this cycle
- hold_issue  out  1  issue queue must not wake a uop this cycle

Behaviour:
- Reset (rst low, async): S1 valid=0; FIFO empty with pointers and count 0; valid_addr=0, addr=0, tag_rob_addr=0, hold_issue=0; rf_raddr=0.
- S1 register: at each posedge, s1_valid<=ready_awake, and Pj/imm/tag are captured. When ready_awake=0, the payload is don't-care but is cleared to 0.
- S1 cycle:
  - rf_raddr=s1_Pj.
  - base is data_cdb[i] from the lowest-index lane i with ready_cdb[i]&&RegWr_cdb[i]&&Pd_cdb[i]==s1_Pj; otherwise base is rf_rdata.
  - addr_s1=base+imm, 32-bit wrap, no overflow flag.
- Push: if s1_valid, {addr_s1, s1_tag} is written at FIFO tail at the next edge.
- Latency: ready_awake at edge T gives valid_addr visible after edge T+2 (FIFO previously empty).
- Pop: the head retires at an edge where valid_addr&&ready_lsu. valid_addr=(count!=0). Outputs come straight from head entry storage. Fall-through of the entry being pushed in the same cycle is not allowed.
- Simultaneous push and pop: count unchanged; legal even when count==DEPTH.
- hold_issue = (count >= DEPTH-2), combinational from registered count. This reserves room for one uop in S1 plus one already issued.
- Push while full without pop: must not happen. Covered by a simulation assertion; the entry is dropped and state is unchanged.
- Pointer wrap-around modulo DEPTH. count spans 0..DEPTH.
- Flush (synchronous, sampled at posedge):
  - Clears s1_valid and empties the FIFO, dropping any same-cycle push and pop.
  - The next-cycle outputs equal their reset values.
  - ready_awake in the flush cycle is discarded.
- Flush has priority over push, pop and hold.
- Reset mid-operation: immediate return to reset state, independent of clk.

Optional Feature:
- Macro AGU_PERF_CNT_EN. When defined, adds two outputs:
  - perf_addr_cnt (32): increments on every pop.
  - perf_hold_cnt (32): increments every cycle hold_issue=1.
- Both counters reset to 0 by rst, are unaffected by flush, and wrap at 2^32.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package agu_pkg:
  - typedef agu_entry_t packed {addr[31:0], tag_rob[5:0]}
  - constants CDB_LANES=5, PREG_W=6, ROB_W=6
- Sub-module agu_fifo: parameterized DEPTH synchronous FIFO of agu_entry_t. Provides push, pop, flush, count, and head outputs.
- Bypass mux and adder stay inline in agu_pipe.

Test Plan:
- Single uop, no bypass: Pj=5, imm=0x10, rf[5]=0x1000, tag=3, ready_lsu=1 -> two edges later valid_addr=1, addr=0x1010, tag_rob_addr=3, popped the next edge.
- CDB bypass priority: lanes 1 and 3 both broadcast Pd=7 while S1 holds Pj=7, imm=-4, rf=0xDEAD, data_cdb[1]=0x2000, data_cdb[3]=0x3000 -> addr=0x1FFC.
- Wrap-around add: base=0xFFFF_FFF0, imm=0x20 -> addr=0x0000_0010.
- Backpressure: ready_lsu=0, one uop issued per cycle honouring hold_issue -> hold_issue rises when count reaches 2, no overflow assertion fires, and all 4 entries drain in order once ready_lsu=1.
- Flush while FIFO holds 3 entries and S1 valid -> next cycle valid_addr=0, hold_issue=0, count=0, and no entry from before the flush ever appears.
- With AGU_PERF_CNT_EN: 5 pops and 3 hold cycles -> perf_addr_cnt=5, perf_hold_cnt=3; the counts are unchanged after a flush and become 0 after rst.
